// File: rtl/register_bank_mem_uret_pkg.sv
// Shared constants for the register bank: FSM encoding, fill-select codes
// and a width helper used to check that the sweep pointer fits AddrBits.
package register_bank_mem_uret_pkg;

  // Sweep FSM encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  // Fill value selection for a sweep
  localparam logic [0:0] FILL_ZERO   = 1'b0;
  localparam logic [0:0] FILL_PRESET = 1'b1;

  // Smallest w with 2**w >= n
  function automatic int clog2_w(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << w) < n) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/register_bank_mem_uret_if.sv
// Bus bundle for the register bank.
// Handshake: there is no ready path. Every request (WrEn, RdEn, ClrReq,
// PreReq) is sampled only on a qualified step (ClockEnable & Tick) and is
// either performed or reported (WrErr) on that same edge; RdValid and WrErr
// are single-clock responses registered on the sampling edge.
interface register_bank_mem_uret_if #(
  parameter int NrOfBits = 8,
  parameter int AddrBits = 4
);
  logic                WrEn;
  logic [AddrBits-1:0] WrAddr;
  logic [NrOfBits-1:0] WrData;
  logic [NrOfBits-1:0] WrMask;
  logic                RdEn;
  logic [AddrBits-1:0] RdAddr;
  logic [NrOfBits-1:0] RdData;
  logic                RdValid;
  logic                ClrReq;
  logic                PreReq;
  logic                Busy;
  logic                WrErr;
  logic [0:0]          SweepState;

  modport master (
    output WrEn, WrAddr, WrData, WrMask, RdEn, RdAddr, ClrReq, PreReq,
    input  RdData, RdValid, Busy, WrErr, SweepState
  );

  modport slave (
    input  WrEn, WrAddr, WrData, WrMask, RdEn, RdAddr, ClrReq, PreReq,
    output RdData, RdValid, Busy, WrErr, SweepState
  );
endinterface

// File: rtl/register_bank_mem_uret_sweep_ctrl.sv
// Sweep engine: walks a pointer over every entry, one entry per step,
// writing the selected fill value. Requests arriving mid-sweep are ignored.
module sweep_ctrl_uret
  import register_bank_mem_uret_pkg::*;
#(
  parameter int NrOfRegs = 16,
  parameter int AddrBits = 4
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic                Step,
  input  logic                ClrReq,
  input  logic                PreReq,
  output logic                Busy,
  output logic                SweepWe,
  output logic [AddrBits-1:0] SweepPtr,
  output logic [0:0]          FillSel,
  output logic [0:0]          State
);

  localparam logic [AddrBits-1:0] LastPtr = AddrBits'(NrOfRegs - 1);

  logic [0:0]          state_q;
  logic [AddrBits-1:0] ptr_q;
  logic [0:0]          fill_q;

  // FSM, pointer and fill register; clear wins over preset
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      fill_q  <= FILL_ZERO;
    end else if (Step) begin
      case (state_q)
        ST_IDLE: begin
          if (ClrReq) begin
            state_q <= ST_SWEEP;
            fill_q  <= FILL_ZERO;
            ptr_q   <= '0;
          end else if (PreReq) begin
            state_q <= ST_SWEEP;
            fill_q  <= FILL_PRESET;
            ptr_q   <= '0;
          end
        end
        ST_SWEEP: begin
          if (ptr_q == LastPtr) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
          end else begin
            ptr_q <= ptr_q + AddrBits'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Busy     = (state_q == ST_SWEEP);
  assign SweepWe  = Step && (state_q == ST_SWEEP);
  assign SweepPtr = ptr_q;
  assign FillSel  = fill_q;
  assign State    = state_q;

endmodule

// File: rtl/register_bank_mem_uret.sv
// Register bank: NrOfRegs x NrOfBits storage with one masked write port,
// one registered read-first read port and a clear/preset sweep engine.
module register_bank_mem_uret
  import register_bank_mem_uret_pkg::*;
#(
  parameter int                NrOfBits    = 8,
  parameter int                NrOfRegs    = 16,
  parameter int                AddrBits    = 4,
  parameter logic [NrOfBits-1:0] PresetValue = '1
) (
  input  logic Clock,
  input  logic Reset_n,
  input  logic ClockEnable,
  input  logic Tick,
  register_bank_mem_uret_if.slave bus
);

  if (NrOfRegs < 2 || clog2_w(NrOfRegs) > AddrBits) begin : g_bad_size
    $error("register_bank_mem_uret: NrOfRegs must be in 2..2**AddrBits");
  end

  localparam logic [AddrBits:0] NRegs = (AddrBits + 1)'(NrOfRegs);

  logic                step;
  logic                busy;
  logic                sweep_we;
  logic [AddrBits-1:0] sweep_ptr;
  logic [0:0]          fill_sel;
  logic [0:0]          state;
  logic                wr_oor;
  logic                rd_oor;
  logic [NrOfBits-1:0] fill_val;
  logic [NrOfBits-1:0] mem [NrOfRegs];

  assign step     = ClockEnable & Tick;
  assign wr_oor   = ({1'b0, bus.WrAddr} >= NRegs);
  assign rd_oor   = ({1'b0, bus.RdAddr} >= NRegs);
  assign fill_val = (fill_sel == FILL_PRESET) ? PresetValue : '0;

  sweep_ctrl_uret #(
    .NrOfRegs (NrOfRegs),
    .AddrBits (AddrBits)
  ) u_sweep (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Step     (step),
    .ClrReq   (bus.ClrReq),
    .PreReq   (bus.PreReq),
    .Busy     (busy),
    .SweepWe  (sweep_we),
    .SweepPtr (sweep_ptr),
    .FillSel  (fill_sel),
    .State    (state)
  );

  // Storage: sweep fill has the array while busy, otherwise the masked write
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NrOfRegs; i++) mem[i] <= '0;
    end else if (sweep_we) begin
      mem[sweep_ptr] <= fill_val;
    end else if (step && bus.WrEn && !busy && !wr_oor) begin
      mem[bus.WrAddr] <= (mem[bus.WrAddr] & ~bus.WrMask) | (bus.WrData & bus.WrMask);
    end
  end

  // Registered read port (read-first) plus RdValid/WrErr pulses
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      bus.RdData  <= '0;
      bus.RdValid <= 1'b0;
      bus.WrErr   <= 1'b0;
    end else begin
      bus.RdValid <= step && bus.RdEn;
      bus.WrErr   <= step && bus.WrEn && (busy || wr_oor);
      if (step && bus.RdEn) begin
        bus.RdData <= rd_oor ? '0 : mem[bus.RdAddr];
      end
    end
  end

  assign bus.Busy       = busy;
  assign bus.SweepState = state;

endmodule

// File: tb/tb_register_bank_mem_uret.sv
// Directed + random bench for register_bank_mem_uret with a spec-level model.
module tb_register_bank_mem_uret;

  logic clk;
  logic rst_n;
  logic ce;
  logic tick;

  register_bank_mem_uret_if #(.NrOfBits(8), .AddrBits(4)) bus ();
  register_bank_mem_uret_if #(.NrOfBits(8), .AddrBits(4)) b12 ();

  register_bank_mem_uret #(.NrOfBits(8), .NrOfRegs(16), .AddrBits(4)) dut (
    .Clock(clk), .Reset_n(rst_n), .ClockEnable(ce), .Tick(tick), .bus(bus.slave)
  );

  // Second instance with 12 entries sees the same stimulus
  register_bank_mem_uret #(.NrOfBits(8), .NrOfRegs(12), .AddrBits(4)) dut12 (
    .Clock(clk), .Reset_n(rst_n), .ClockEnable(ce), .Tick(tick), .bus(b12.slave)
  );

  assign b12.WrEn   = bus.WrEn;
  assign b12.WrAddr = bus.WrAddr;
  assign b12.WrData = bus.WrData;
  assign b12.WrMask = bus.WrMask;
  assign b12.RdEn   = bus.RdEn;
  assign b12.RdAddr = bus.RdAddr;
  assign b12.ClrReq = bus.ClrReq;
  assign b12.PreReq = bus.PreReq;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // reference model (16 entries, preset 0xFF)
  logic [7:0] m_mem [16];
  bit         m_sweeping;
  int         m_idx;
  logic [7:0] m_fill;
  logic [7:0] m_rd;
  bit         m_valid;
  bit         m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_sweeping = 0;
    m_idx      = 0;
    m_fill     = 8'h00;
    m_rd       = 8'h00;
    m_valid    = 0;
    m_err      = 0;
  endtask

  // One clock: drive, predict, then check after the edge
  task automatic cycle(input bit c, input bit t, input bit we, input logic [3:0] wa,
                       input logic [7:0] wd, input logic [7:0] wm, input bit re,
                       input logic [3:0] ra, input bit cr, input bit pr);
    bit st;
    ce = c; tick = t;
    bus.WrEn = we; bus.WrAddr = wa; bus.WrData = wd; bus.WrMask = wm;
    bus.RdEn = re; bus.RdAddr = ra; bus.ClrReq = cr; bus.PreReq = pr;
    st      = c && t;
    m_valid = st && re;
    m_err   = st && we && m_sweeping;
    if (m_valid) m_rd = m_mem[ra];
    if (st) begin
      if (m_sweeping) begin
        m_mem[m_idx] = m_fill;
        m_idx++;
        if (m_idx == 16) m_sweeping = 0;
      end else begin
        if (we) m_mem[wa] = (m_mem[wa] & ~wm) | (wd & wm);
        if (cr) begin
          m_sweeping = 1; m_idx = 0; m_fill = 8'h00;
        end else if (pr) begin
          m_sweeping = 1; m_idx = 0; m_fill = 8'hFF;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("rd_valid", 32'(bus.RdValid), 32'(m_valid));
    chk("wr_err",   32'(bus.WrErr),   32'(m_err));
    chk("busy",     32'(bus.Busy),    32'(m_sweeping));
    chk("rd_data",  32'(bus.RdData),  32'(m_rd));
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input logic [7:0] m);
    cycle(1, 1, 1, a, d, m, 0, 4'd0, 0, 0);
  endtask

  task automatic rd(input logic [3:0] a);
    cycle(1, 1, 0, 4'd0, 8'h00, 8'h00, 1, a, 0, 0);
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) rd(4'(i));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; ce = 0; tick = 0;
    bus.WrEn = 0; bus.WrAddr = 0; bus.WrData = 0; bus.WrMask = 0;
    bus.RdEn = 0; bus.RdAddr = 0; bus.ClrReq = 0; bus.PreReq = 0;
    model_reset();
    #12;
    chk("reset_rd_data",  32'(bus.RdData),  0);
    chk("reset_rd_valid", 32'(bus.RdValid), 0);
    chk("reset_busy",     32'(bus.Busy),    0);
    chk("reset_wr_err",   32'(bus.WrErr),   0);
    chk("reset12_busy",   32'(b12.Busy),    0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic write / read and masked write
    wr(4'd3, 8'hA5, 8'hFF);
    rd(4'd3);
    chk("rd_a5", 32'(bus.RdData), 32'h0A5);
    wr(4'd3, 8'h3C, 8'h0F);
    rd(4'd3);
    chk("rd_ac", 32'(bus.RdData), 32'h0AC);

    // out-of-range handling on the 12-entry instance
    wr(4'd15, 8'h99, 8'hFF);
    chk("n12_wr15_err", 32'(b12.WrErr), 1);
    rd(4'd15);
    chk("n12_rd15_data",  32'(b12.RdData),  0);
    chk("n12_rd15_valid", 32'(b12.RdValid), 1);
    wr(4'd11, 8'h5A, 8'hFF);
    chk("n12_wr11_err", 32'(b12.WrErr), 0);
    wr(4'd12, 8'h66, 8'hFF);
    chk("n12_wr12_err", 32'(b12.WrErr), 1);
    rd(4'd11);
    chk("n12_rd11", 32'(b12.RdData), 32'h05A);
    wr(4'd11, 8'h00, 8'hF0);
    rd(4'd11);
    chk("n12_rd11_mask", 32'(b12.RdData), 32'h00A);

    // same-step read and write: read-first
    wr(4'd5, 8'h11, 8'hFF);
    cycle(1, 1, 1, 4'd5, 8'h22, 8'hFF, 1, 4'd5, 0, 0);
    chk("rw_old", 32'(bus.RdData), 32'h011);
    rd(4'd5);
    chk("rw_new", 32'(bus.RdData), 32'h022);

    // clear sweep: 16 steps, write inside is dropped, preset request ignored
    cycle(1, 1, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 1, 0);
    n = 0;
    while (bus.Busy === 1'b1 && n < 64) begin
      cycle(1, 1, n == 4, 4'(n), 8'h77, 8'hFF, 1, 4'(n), 0, n == 6);
      n++;
    end
    chk("clr_sweep_steps", 32'(n), 16);
    read_all();

    // clear and preset together: clear wins; write on request step is overwritten
    cycle(1, 1, 1, 4'd2, 8'h44, 8'hFF, 0, 4'd0, 1, 1);
    n = 0;
    while (bus.Busy === 1'b1 && n < 64) begin
      cycle(1, 1, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 0, 0);
      n++;
    end
    chk("both_sweep_steps", 32'(n), 16);
    read_all();
    rd(4'd2);
    chk("both_rd2_zero", 32'(bus.RdData), 0);

    // preset sweep
    cycle(1, 1, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 0, 1);
    n = 0;
    while (bus.Busy === 1'b1 && n < 64) begin
      cycle(1, 1, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 0, 0);
      n++;
    end
    chk("pre_sweep_steps", 32'(n), 16);
    read_all();
    rd(4'd9);
    chk("pre_rd9", 32'(bus.RdData), 32'h0FF);

    // sparse tick: clear sweep takes 32 clocks
    cycle(1, 1, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 1, 0);
    n = 0;
    while (bus.Busy === 1'b1 && n < 100) begin
      cycle(1, n % 2 == 1, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 0, 0);
      n++;
    end
    chk("sparse_sweep_clocks", 32'(n), 32);

    // preset sweep aborted by reset after 7 steps
    cycle(1, 1, 0, 4'd0, 8'h00, 8'h00, 0, 4'd0, 0, 1);
    for (int i = 0; i < 7; i++) cycle(1, 1, 0, 4'd0, 8'h00, 8'h00, 1, 4'(i), 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("abort_busy",     32'(bus.Busy),    0);
    chk("abort_rd_valid", 32'(bus.RdValid), 0);
    chk("abort_rd_data",  32'(bus.RdData),  0);
    @(negedge clk);
    rst_n = 1'b1;
    read_all();

    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
            8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
            $urandom_range(0, 40) == 0, $urandom_range(0, 40) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
